// File: rtl/ct_arb_pkg.sv
// ct_arb_pkg: shared defaults and FSM state type for the ciphertext read arbiter.
package ct_arb_pkg;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;

    // One access in flight: sample/latch in IDLE, memory reads in ISSUE,
    // data is registered on the CAPTURE -> IDLE edge.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } arb_state_e;

endpackage : ct_arb_pkg

// File: rtl/ct_arbiter_if.sv
// ct_arbiter_if: requester-side bundle of the ciphertext read arbiter.
// master = requester side, slave = arbiter side.
interface ct_arbiter_if #(
    parameter int NUM_REQ = ct_arb_pkg::DEF_NUM_REQ,
    parameter int ADDR_W  = ct_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W  = ct_arb_pkg::DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rdvalid;
    logic [DATA_W-1:0]         rddata;
    logic                      busy;

    modport master (
        output req, addr,
        input  gnt, rdvalid, rddata, busy
    );

    modport slave (
        input  req, addr,
        output gnt, rdvalid, rddata, busy
    );
endinterface : ct_arbiter_if

// File: rtl/ct_arbiter_rr_pick.sv
// rr_pick: combinational winner selection. Searches cyclically starting
// at the port after 'last'; tying 'last' to NUM_REQ-1 yields fixed
// lowest-index priority.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner
);
    int   idx;
    logic found;

    // First requesting port after 'last', one-hot encoded.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end
endmodule : rr_pick

// File: rtl/ct_arbiter.sv
// ct_arbiter: arbitrates NUM_REQ read requesters onto one single-port
// ciphertext memory with a 1-cycle read latency. One access in flight.
// Build option: define CT_ARB_ROUND_ROBIN_EN for round-robin on contention;
// otherwise lowest-index requester always wins.
module ct_arbiter
    import ct_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    ct_arbiter_if.slave       bus,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state;
    logic [NUM_REQ-1:0] winner;
    logic [NUM_REQ-1:0] owner;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] rdvalid_q;
    logic [DATA_W-1:0]  rddata_q;
    logic [ADDR_W-1:0]  sel_addr;
    logic [PTR_W-1:0]   last;

`ifdef CT_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] win_idx;

    // Index of the one-hot winner, used to advance the pointer.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) win_idx = PTR_W'(i);
        end
    end

    // Last-granted pointer; starts at NUM_REQ-1 so port 0 leads after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= PTR_W'(NUM_REQ - 1);
        end else if (state == ST_IDLE && |bus.req) begin
            last <= win_idx;
        end
    end
`else
    // Fixed priority: a constant pointer makes the cyclic search start at port 0.
    assign last = PTR_W'(NUM_REQ - 1);
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (bus.req),
        .last   (last),
        .winner (winner)
    );

    // Address slice belonging to the winning port.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) sel_addr = bus.addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Access FSM with registered gnt/rdvalid/rddata/mem_addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            gnt_q     <= '0;
            rdvalid_q <= '0;
            rddata_q  <= '0;
            mem_addr  <= '0;
        end else begin
            // NOTE: non-blocking so every branch reads pre-edge state.
            gnt_q     <= '0;
            rdvalid_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        owner    <= winner;
                        gnt_q    <= winner;
                        mem_addr <= sel_addr;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rddata_q  <= mem_q;
                    rdvalid_q <= owner;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.rdvalid = rdvalid_q;
    assign bus.rddata  = rddata_q;
    assign bus.busy    = (state != ST_IDLE);

endmodule : ct_arbiter

// File: tb/tb_ct_arbiter.sv
// tb_ct_arbiter: directed self-checking bench for ct_arbiter (2 ports, 8/8 bits).
// Expectations follow CT_ARB_ROUND_ROBIN_EN when the contention test runs.
module tb_ct_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] mem_addr;
    logic [7:0] mem_q;
    logic [7:0] mem [256];

    int tests;
    int fails;

    ct_arbiter_if #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8)) bus ();

    ct_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_q    (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model: data one clock after the address is sampled.
    always @(posedge clk) mem_q <= mem[mem_addr];

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},      32'(bus.gnt),     32'h0);
        check({tag, "_rdvalid"},  32'(bus.rdvalid), 32'h0);
        check({tag, "_busy"},     32'(bus.busy),    32'h0);
        check({tag, "_mem_addr"}, 32'(mem_addr),    32'h0);
        check({tag, "_rddata"},   32'(bus.rddata),  32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Expected grant port / data for four back-to-back accesses with req=2'b11.
`ifdef CT_ARB_ROUND_ROBIN_EN
    logic [1:0] exp_gnt  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] exp_data [4] = '{8'h37, 8'h67, 8'h37, 8'h67};
`else
    logic [1:0] exp_gnt  [4] = '{2'b01, 2'b01, 2'b01, 2'b01};
    logic [7:0] exp_data [4] = '{8'h37, 8'h37, 8'h37, 8'h37};
`endif

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 7);
        mem[8'h1F] = 8'hA5;
        mem[8'hFF] = 8'h3C;
        mem[8'h00] = 8'hC3;
        // Untouched entries used below: mem[0x10]=0x37, mem[0x20]=0x67.

        bus.req  = '0;
        bus.addr = '0;
        rst      = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();
        check("idle_no_req_gnt", 32'(bus.gnt), 32'h0);

        // Single request on port 0, addr 0x1F.
        bus.req  = 2'b01;
        bus.addr = {8'h00, 8'h1F};
        tick();
        check("single_gnt",      32'(bus.gnt),  32'h1);
        check("single_busy",     32'(bus.busy), 32'h1);
        check("single_mem_addr", 32'(mem_addr), 32'h1F);
        bus.req = 2'b00;
        tick();
        check("single_gnt_pulse", 32'(bus.gnt),     32'h0);
        check("single_no_early",  32'(bus.rdvalid), 32'h0);
        tick();
        check("single_rdvalid", 32'(bus.rdvalid), 32'h1);
        check("single_rddata",  32'(bus.rddata),  32'hA5);
        check("single_idle",    32'(bus.busy),    32'h0);
        tick();
        check("single_rdvalid_pulse", 32'(bus.rdvalid), 32'h0);
        check("rddata_hold",          32'(bus.rddata),  32'hA5);
        check("no_req_no_gnt",        32'(bus.gnt),     32'h0);

        // Contention: both ports held high for four accesses.
        do_reset();
        bus.req  = 2'b11;
        bus.addr = {8'h20, 8'h10};
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("cont_gnt_%0d", k), 32'(bus.gnt), 32'(exp_gnt[k]));
            tick();
            tick();
            check($sformatf("cont_rdvalid_%0d", k), 32'(bus.rdvalid), 32'(exp_gnt[k]));
            check($sformatf("cont_rddata_%0d", k),  32'(bus.rddata),  32'(exp_data[k]));
        end
        bus.req = 2'b00;
        tick();
        check("cont_release_gnt", 32'(bus.gnt), 32'h0);

        // Reset in ISSUE aborts the access.
        bus.req  = 2'b10;
        bus.addr = {8'h1F, 8'h00};
        tick();
        check("abort_gnt", 32'(bus.gnt), 32'h2);
        bus.req = 2'b00;
        rst     = 1'b1;
        #1;
        check_idle_outputs("abort_rst");
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("abort_no_rdvalid_%0d", k), 32'(bus.rdvalid), 32'h0);
        end
        bus.req = 2'b10;
        tick();
        check("after_abort_gnt", 32'(bus.gnt), 32'h2);
        bus.req = 2'b00;
        tick();
        tick();
        check("after_abort_rdvalid", 32'(bus.rdvalid), 32'h2);
        check("after_abort_rddata",  32'(bus.rddata),  32'hA5);

        // Port 1: 0xFF then 0x00 back to back.
        tick();
        bus.req  = 2'b10;
        bus.addr = {8'hFF, 8'h00};
        tick();
        check("edge_gnt_ff",      32'(bus.gnt),  32'h2);
        check("edge_mem_addr_ff", 32'(mem_addr), 32'hFF);
        bus.addr = {8'h00, 8'h00};
        tick();
        tick();
        check("edge_rdvalid_ff", 32'(bus.rdvalid), 32'h2);
        check("edge_rddata_ff",  32'(bus.rddata),  32'h3C);
        tick();
        check("edge_gnt_00",      32'(bus.gnt),  32'h2);
        check("edge_mem_addr_00", 32'(mem_addr), 32'h00);
        bus.req = 2'b00;
        tick();
        tick();
        check("edge_rdvalid_00", 32'(bus.rdvalid), 32'h2);
        check("edge_rddata_00",  32'(bus.rddata),  32'hC3);

        // Port 1 pulses while port 0's access is in flight: never granted.
        tick();
        bus.req  = 2'b01;
        bus.addr = {8'h20, 8'h10};
        tick();
        check("wd_gnt0", 32'(bus.gnt), 32'h1);
        bus.req = 2'b10;
        tick();
        check("wd_gnt_issue", 32'(bus.gnt), 32'h0);
        bus.req = 2'b00;
        tick();
        check("wd_rdvalid", 32'(bus.rdvalid), 32'h1);
        check("wd_rddata",  32'(bus.rddata),  32'h37);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("wd_no_gnt1_%0d", k), 32'(bus.gnt),  32'h0);
            check($sformatf("wd_idle_%0d", k),    32'(bus.busy), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ct_arbiter
